// File: rtl/wb_interconnect_arb_wrr.sv
// Wishbone bus arbiter: weighted round-robin or fixed priority, registered one-hot grant.
// Each tenure allows up to weight transfers and is always followed by at least one idle cycle.
module wb_interconnect_arb_wrr #(
    parameter int N_REQ    = 4,
    parameter int WEIGHT_W = 4,
    parameter int MODE     = 0,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*WEIGHT_W-1:0]   weight,
    input  logic                        ack,
    output logic [N_REQ-1:0]            gnt,
    output logic [IDX_W-1:0]            gnt_idx,
    output logic                        gnt_valid
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0]    LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [WEIGHT_W-1:0] ONE_W    = WEIGHT_W'(1);

    state_t                 state_r, state_nxt_s;
    logic [N_REQ-1:0]       gnt_r, gnt_nxt_s;
    logic [IDX_W-1:0]       gnt_idx_r, gnt_idx_nxt_s;
    logic [IDX_W-1:0]       last_idx_r, last_idx_nxt_s;
    logic [IDX_W-1:0]       win_idx_s, pick_s;
    logic                   gnt_valid_r, gnt_valid_nxt_s;
    logic                   armed_r;
    logic                   win_found_s, held_s, start_s, release_s;
    logic [WEIGHT_W-1:0]    cnt_r, cnt_nxt_s, win_weight_s, win_load_s;
    int                     base_s;

    // Winner search: rotating start above last_idx, or index 0 in fixed-priority mode.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        pick_s      = '0;
        base_s      = (MODE == 1) ? 0 : int'(last_idx_r) + 1;
        for (int k = 0; k < N_REQ; k++) begin
            pick_s = IDX_W'((base_s + k) % N_REQ);
            if (!win_found_s && req[pick_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = pick_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Weight of the winner; zero means a single transfer.
    always_comb begin
        win_weight_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == win_idx_s) begin
                win_weight_s = weight[i*WEIGHT_W +: WEIGHT_W];
            end else begin
                win_weight_s = win_weight_s;
            end
        end
        win_load_s = (win_weight_s == '0) ? ONE_W : win_weight_s;
    end

    assign held_s = req[gnt_idx_r];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; armed_r keeps the first post-reset edge grant-free.
    always_comb begin
        start_s     = 1'b0;
        release_s   = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (armed_r && win_found_s) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!held_s || (ack && (cnt_r <= ONE_W))) begin
                    release_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and counter next values.
    always_comb begin
        gnt_nxt_s       = gnt_r;
        gnt_idx_nxt_s   = gnt_idx_r;
        gnt_valid_nxt_s = gnt_valid_r;
        cnt_nxt_s       = cnt_r;
        last_idx_nxt_s  = last_idx_r;
        if (start_s) begin
            gnt_nxt_s       = N_REQ'(1'b1) << win_idx_s;
            gnt_idx_nxt_s   = win_idx_s;
            gnt_valid_nxt_s = 1'b1;
            cnt_nxt_s       = win_load_s;
        end else if (release_s) begin
            gnt_nxt_s       = '0;
            gnt_idx_nxt_s   = '0;
            gnt_valid_nxt_s = 1'b0;
            cnt_nxt_s       = '0;
            last_idx_nxt_s  = gnt_idx_r;
        end else if ((state_r == ST_GRANT) && ack) begin
            cnt_nxt_s = cnt_r - ONE_W;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Output and counter registers; reset drops the grant without a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_r       <= '0;
            gnt_idx_r   <= '0;
            gnt_valid_r <= 1'b0;
            cnt_r       <= '0;
            last_idx_r  <= LAST_RST;
            armed_r     <= 1'b0;
        end else begin
            gnt_r       <= gnt_nxt_s;
            gnt_idx_r   <= gnt_idx_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
            cnt_r       <= cnt_nxt_s;
            last_idx_r  <= last_idx_nxt_s;
            armed_r     <= 1'b1;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_wb_interconnect_arb_wrr.sv
// Directed bench for wb_interconnect_arb_wrr: round-robin instance plus a fixed-priority instance.
module tb_wb_interconnect_arb_wrr;

    logic        clock;
    logic        reset;
    logic [3:0]  req, req_fp;
    logic [15:0] weight, weight_fp;
    logic        ack, ack_fp;
    logic [3:0]  gnt, gnt_fp;
    logic [1:0]  gnt_idx, gnt_idx_fp;
    logic        gnt_valid, gnt_valid_fp;
    logic [3:0]  prev_gnt, prev_gnt_fp;

    int checks = 0;
    int errors = 0;
    int exp_seq [4] = '{1, 2, 3, 0};

    wb_interconnect_arb_wrr #(.N_REQ(4), .WEIGHT_W(4), .MODE(0)) dut (
        .clock(clock), .reset(reset), .req(req), .weight(weight), .ack(ack),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    wb_interconnect_arb_wrr #(.N_REQ(4), .WEIGHT_W(4), .MODE(1)) dut_fp (
        .clock(clock), .reset(reset), .req(req_fp), .weight(weight_fp), .ack(ack_fp),
        .gnt(gnt_fp), .gnt_idx(gnt_idx_fp), .gnt_valid(gnt_valid_fp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-hot, valid/index consistency and idle gap between different grants.
    task automatic inv(input string tag, input logic [3:0] g, input logic [1:0] gi,
                       input logic gv, input logic [3:0] pg);
        chk({tag, "_onehot"}, 32'($onehot0(g)), 32'd1);
        chk({tag, "_valid"}, 32'(gv), 32'(g != 4'd0));
        if (gv) chk({tag, "_idx"}, 32'(g), 32'(4'd1 << gi));
        if ((pg != 4'd0) && (g != 4'd0)) chk({tag, "_gap"}, 32'(g), 32'(pg));
    endtask

    task automatic tick();
        prev_gnt    = gnt;
        prev_gnt_fp = gnt_fp;
        @(posedge clock);
        #1;
        inv("inv", gnt, gnt_idx, gnt_valid, prev_gnt);
        inv("inv_fp", gnt_fp, gnt_idx_fp, gnt_valid_fp, prev_gnt_fp);
    endtask

    initial begin
        reset = 1'b1; req = 4'd0; ack = 1'b0; weight = 16'h1111;
        req_fp = 4'd0; ack_fp = 1'b0; weight_fp = 16'h1111;
        prev_gnt = 4'd0; prev_gnt_fp = 4'd0;
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        chk("rst_gnt_fp", 32'(gnt_fp), 32'h0);
        tick(); tick();

        // Release with everyone requesting: one arming edge, then requester 0.
        reset = 1'b0; req = 4'b1111;
        tick(); chk("arm_gap", 32'(gnt), 32'h0);
        tick(); chk("first_gnt", 32'(gnt), 32'h1); chk("first_idx", 32'(gnt_idx), 32'h0);
        repeat (3) begin tick(); chk("hold_no_ack", 32'(gnt), 32'h1); end

        // Round robin with weights 1.
        for (int i = 0; i < 4; i++) begin
            ack = 1'b1; tick(); chk("rr_gap", 32'(gnt), 32'h0);
            ack = 1'b0; tick();
            chk("rr_gnt", 32'(gnt), 32'(4'd1 << exp_seq[i]));
            chk("rr_idx", 32'(gnt_idx), 32'(exp_seq[i]));
        end

        // Weight 3 on requester 1: three acks in one tenure.
        weight = 16'h1131; ack = 1'b1; req = 4'b0010;
        tick(); chk("w3_rel0", 32'(gnt), 32'h0);
        ack = 1'b0;
        tick(); chk("w3_gnt", 32'(gnt), 32'h2);
        ack = 1'b1;
        tick(); chk("w3_ack1", 32'(gnt), 32'h2);
        tick(); chk("w3_ack2", 32'(gnt), 32'h2);
        tick(); chk("w3_ack3", 32'(gnt), 32'h0);
        ack = 1'b0;
        tick(); chk("w3_regnt", 32'(gnt), 32'h2);
        req = 4'd0;
        tick(); chk("w3_drop", 32'(gnt), 32'h0);

        // Weight 5 on requester 2, abandoned after two acks.
        weight = 16'h1531; req = 4'b0100;
        tick(); chk("w5_gnt", 32'(gnt), 32'h4); chk("w5_idx", 32'(gnt_idx), 32'h2);
        ack = 1'b1;
        tick(); chk("w5_ack1", 32'(gnt), 32'h4);
        tick(); chk("w5_ack2", 32'(gnt), 32'h4);
        ack = 1'b0; req = 4'b1000;
        tick(); chk("w5_drop", 32'(gnt), 32'h0);
        tick(); chk("w5_next", 32'(gnt), 32'h8); chk("w5_next_idx", 32'(gnt_idx), 32'h3);

        // Asynchronous reset while requester 2 holds the bus.
        req = 4'd0;
        tick(); chk("pre_rst_rel", 32'(gnt), 32'h0);
        req = 4'b0100;
        tick(); chk("pre_rst_gnt", 32'(gnt), 32'h4);
        #3 reset = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_valid", 32'(gnt_valid), 32'h0);
        chk("async_idx", 32'(gnt_idx), 32'h0);
        req = 4'b1111; weight = 16'h1530;
        tick(); chk("in_rst", 32'(gnt), 32'h0);
        reset = 1'b0;
        tick(); chk("rel_gap", 32'(gnt), 32'h0);
        tick(); chk("rel_gnt", 32'(gnt), 32'h1); chk("rel_idx", 32'(gnt_idx), 32'h0);

        // Weight 0 on requester 0 with ack every cycle, including in idle.
        ack = 1'b1; req = 4'b0001;
        repeat (3) begin
            tick(); chk("w0_rel", 32'(gnt), 32'h0);
            tick(); chk("w0_gnt", 32'(gnt), 32'h1);
        end
        ack = 1'b0; req = 4'd0;
        tick(); chk("w0_end", 32'(gnt), 32'h0);

        // Fixed priority: requester 1 always beats 3.
        req_fp = 4'b1010;
        tick(); chk("fp_gnt0", 32'(gnt_fp), 32'h2);
        for (int t = 0; t < 3; t++) begin
            ack_fp = 1'b1; tick(); chk("fp_gap", 32'(gnt_fp), 32'h0);
            ack_fp = 1'b0; tick();
            chk("fp_gnt", 32'(gnt_fp), 32'h2);
            chk("fp_idx", 32'(gnt_idx_fp), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
